// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the wide_add_seq byte-serial adder.
// Contents:
//   SLICE_W : width of the single carry-select slice that is reused each cycle
//   state_t : sequencer states (IDLE accepts, RUN walks the bytes, DONE presents)
package wide_add_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wide_add_seq_csa_8_cin.sv
// 8-bit carry-select adder slice with carry-in.
// Ports:
//   a, b  : 8-bit addends
//   cin   : carry into bit 0
//   sum   : 8-bit result
//   cout  : carry out of bit 7
module csa_8_cin (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [4:0] loSum;
    logic [4:0] hiSum0;
    logic [4:0] hiSum1;

    // Low nibble ripples with the real carry-in, while both possible upper
    // nibble results are formed in parallel and the low-nibble carry picks one.
    always_comb begin
        loSum  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
        hiSum0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
        hiSum1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
        if (loSum[4]) begin
            sum  = {hiSum1[3:0], loSum[3:0]};
            cout = hiSum1[4];
        end else begin
            sum  = {hiSum0[3:0], loSum[3:0]};
            cout = hiSum0[4];
        end
    end

endmodule

// File: rtl/wide_add_seq.sv
// Byte-serial WIDTH-bit add/subtract sequencer built around one 8-bit
// carry-select slice, least-significant byte first.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid, in_ready   : operand handshake (a, b, sub sampled on accept)
//   out_valid, out_ready : result handshake
//   sum, carry, overflow : result, carry out of MSB, signed overflow
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int N     = WIDTH / SLICE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;

    logic [7:0]       sliceA;
    logic [7:0]       sliceB;
    logic [7:0]       sliceSum;
    logic             sliceCout;

    // The current byte of each operand is steered into the shared slice.
    assign sliceA = opA_q[idx_q*SLICE_W +: SLICE_W];
    assign sliceB = opB_q[idx_q*SLICE_W +: SLICE_W];

    csa_8_cin u_slice (
        .a    (sliceA),
        .b    (sliceB),
        .cin  (carry_q),
        .sum  (sliceSum),
        .cout (sliceCout)
    );

    // Sequencer: subtraction is folded in at accept time by storing ~b and
    // seeding the byte carry with 1, so the RUN phase is a plain add.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opA_d   = a;
                    opB_d   = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*SLICE_W +: SLICE_W] = sliceSum;
                carry_d = sliceCout;
                if (idx_q == LAST_IDX) begin
                    // The top slice supplies the result MSB for the overflow test.
                    idx_d   = '0;
                    ovf_d   = (opA_q[WIDTH-1] == opB_q[WIDTH-1]) &&
                              (sliceSum[7] != opA_q[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears any partial result and the
    // inter-byte carry so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            opA_q   <= '0;
            opB_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq (WIDTH=32) using a result scoreboard.
module tb_wide_add_seq;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } expT;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry;
    logic         overflow;

    int  checks;
    int  errors;
    expT sb[$];

    wide_add_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .overflow  (overflow)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result: 33-bit arithmetic for carry, sign rules for overflow
    function automatic expT model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        expT r;
        logic [W:0] full;
        if (s) full = {1'b0, x} + {1'b0, ~y} + 33'd1;
        else   full = {1'b0, x} + {1'b0, y};
        r.sum   = full[W-1:0];
        r.carry = full[W];
        if (s) r.ovf = (x[W-1] != y[W-1]) && (full[W-1] != x[W-1]);
        else   r.ovf = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return r;
    endfunction

    // Presents an operation and pushes its expected result on acceptance
    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        bit done;
        a = x; b = y; sub = s; in_valid = 1'b1;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (in_ready) done = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL accept timeout got in_ready %b want 1", in_ready);
        end else begin
            sb.push_back(model(x, y, s));
        end
        in_valid = 1'b0;
    endtask

    task automatic waitOutValid(output bit ok);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (out_valid) ok = 1;
            else begin @(posedge clk); #1; end
        end
    endtask

    // Waits for a result, compares it with the scoreboard head, then handshakes
    task automatic checkOutput(input string name);
        bit ok;
        expT e;
        waitOutValid(ok);
        checks++;
        if (!ok || sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s result timeout got out_valid %b want 1 (queued %0d)", name, out_valid, sb.size());
        end else begin
            e = sb.pop_front();
            if ({sum, carry, overflow} !== {e.sum, e.carry, e.ovf}) begin
                errors++;
                $display("[TB] FAIL %s got sum %h carry %b ovf %b want sum %h carry %b ovf %b",
                         name, sum, carry, overflow, e.sum, e.carry, e.ovf);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, sum, carry, overflow} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_state got rdy %b vld %b sum %h c %b o %b want 1 0 0 0 0",
                     in_ready, out_valid, sum, carry, overflow);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_latency;
        applyStimulus(32'h000000FF, 32'h00000001, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (out_valid !== (k == 4 ? 1'b0 : 1'b0)) begin
                errors++;
                $display("[TB] FAIL latency edge %0d got out_valid %b want 0", k, out_valid);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL latency edge 4 got out_valid %b want 1", out_valid);
        end
        checkOutput("add_ff_1");
    endtask

    task automatic test_arith;
        applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0); checkOutput("full_ripple");
        applyStimulus(32'h7FFFFFFF, 32'h00000001, 1'b0); checkOutput("signed_ovf");
        applyStimulus(32'd5, 32'd7, 1'b1);               checkOutput("sub_5_7");
        applyStimulus(32'd7, 32'd5, 1'b1);               checkOutput("sub_7_5");
        applyStimulus(32'h80000000, 32'h00000001, 1'b1); checkOutput("sub_ovf");
    endtask

    task automatic test_backpressure;
        bit  ok;
        expT e;
        applyStimulus(32'h12345678, 32'h9ABCDEF0, 1'b0);
        waitOutValid(ok);
        e = sb.pop_front();
        // A new request waits while the result is held
        a = 32'h00000010; b = 32'h00000020; sub = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({out_valid, in_ready, sum, carry, overflow} !== {1'b1, 1'b0, e.sum, e.carry, e.ovf}) begin
                errors++;
                $display("[TB] FAIL backpressure cycle %0d got vld %b rdy %b sum %h c %b o %b want 1 0 %h %b %b",
                         k, out_valid, in_ready, sum, carry, overflow, e.sum, e.carry, e.ovf);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL handshake_no_accept got vld %b rdy %b want 0 1", out_valid, in_ready);
        end
        sb.push_back(model(32'h00000010, 32'h00000020, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pending_accept got in_ready %b want 0", in_ready);
        end
        checkOutput("pending_op");
    endtask

    task automatic test_reset_midrun;
        applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, sum, carry} !== {1'b0, 1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_midrun got vld %b rdy %b sum %h c %b want 0 1 0 0",
                     out_valid, in_ready, sum, carry);
        end
        void'(sb.pop_front());
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(32'h00000001, 32'h00000001, 1'b0);
        checkOutput("after_reset");
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         s;
        for (int i = 0; i < 8; i++) begin
            x = $urandom; y = $urandom; s = 1'($urandom_range(0, 1));
            applyStimulus(x, y, s);
            checkOutput("random_op");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add_latency();
        test_arith();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
